// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU use 32 shift-add steps and DIV/DIVU use 32 restoring-divide steps.
// Both work on operand magnitudes, and the sign is corrected in a final FIX cycle.
module mdu_hilo #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            mthi_we,
  input  logic            mtlo_we,
  input  logic [XLEN-1:0] mt_data,
  output logic            busy,
  output logic            done,
  output logic            div_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam int unsigned AW = 2 * XLEN;
  localparam logic [CW-1:0] LAST_ITER = CW'(XLEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            is_div_q, is_div_d;
  logic [XLEN-1:0] opnd_q, opnd_d;     // multiplicand, or divisor
  logic [XLEN-1:0] sh_q, sh_d;         // multiplier shifting right, or dividend shifting left
  logic [AW-1:0]   acc_q, acc_d;       // product, or {remainder, quotient}
  logic [XLEN-1:0] a_raw_q, a_raw_d;
  logic            neg_q, neg_d;       // product/quotient must be negated
  logic            neg_rem_q, neg_rem_d;
  logic            dz_q, dz_d;         // in-flight divide has a zero divisor
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            div_zero_q, div_zero_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;

  // Operand conditioning: signed ops (MULT, DIV) work on two's-complement magnitudes
  logic            signed_op;
  logic [XLEN-1:0] mag_a, mag_b;
  assign signed_op = ~op[0];
  assign mag_a     = (signed_op && a[XLEN-1]) ? (~a + XLEN'(1)) : a;
  assign mag_b     = (signed_op && b[XLEN-1]) ? (~b + XLEN'(1)) : b;

  // One shift-add multiply step; the carry re-enters at the top of the accumulator
  logic [XLEN:0]   mul_sum;
  logic [AW-1:0]   mul_acc;
  assign mul_sum = {1'b0, acc_q[AW-1:XLEN]} + {1'b0, (sh_q[0] ? opnd_q : '0)};
  assign mul_acc = {mul_sum, acc_q[XLEN-1:1]};

  // One restoring-divide step on a 33-bit partial remainder
  logic [XLEN:0]   part_rem;
  logic [XLEN+1:0] trial;
  logic            qbit;
  logic [XLEN-1:0] rem_next;
  logic [AW-1:0]   div_acc;
  logic            unused_trial_bit;
  assign part_rem         = {acc_q[AW-1:XLEN], sh_q[XLEN-1]};
  assign trial            = {1'b0, part_rem} - {2'b00, opnd_q};
  assign qbit             = ~trial[XLEN+1];
  assign rem_next         = qbit ? trial[XLEN-1:0] : part_rem[XLEN-1:0];
  assign div_acc          = {rem_next, acc_q[XLEN-2:0], qbit};
  assign unused_trial_bit = trial[XLEN];

  // Final sign correction of the magnitude result
  logic [AW-1:0]   fix_prod;
  logic [XLEN-1:0] fix_quo, fix_rem;
  assign fix_prod = neg_q ? (~acc_q + AW'(1)) : acc_q;
  assign fix_quo  = neg_q ? (~acc_q[XLEN-1:0] + XLEN'(1)) : acc_q[XLEN-1:0];
  assign fix_rem  = neg_rem_q ? (~acc_q[AW-1:XLEN] + XLEN'(1)) : acc_q[AW-1:XLEN];

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    opnd_d     = opnd_q;
    sh_d       = sh_q;
    acc_d      = acc_q;
    a_raw_d    = a_raw_q;
    neg_d      = neg_q;
    neg_rem_d  = neg_rem_q;
    dz_d       = dz_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_CALC;
          cnt_d     = '0;
          is_div_d  = op[1];
          opnd_d    = op[1] ? mag_b : mag_a;
          sh_d      = op[1] ? mag_a : mag_b;
          acc_d     = '0;
          a_raw_d   = a;
          neg_d     = signed_op & (a[XLEN-1] ^ b[XLEN-1]);
          neg_rem_d = signed_op & a[XLEN-1];
          dz_d      = op[1] & (b == '0);
          busy_d    = 1'b1;
        end else begin
          if (mthi_we) hi_d = mt_data;
          if (mtlo_we) lo_d = mt_data;
        end
      end

      S_CALC: begin
        if (is_div_q) begin
          acc_d = div_acc;
          sh_d  = {sh_q[XLEN-2:0], 1'b0};
        end else begin
          acc_d = mul_acc;
          sh_d  = {1'b0, sh_q[XLEN-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) state_d = S_FIX;
      end

      S_FIX: begin
        if (is_div_q) begin
          if (dz_q) begin
            hi_d = a_raw_q;
            lo_d = '1;
          end else begin
            hi_d = fix_rem;
            lo_d = fix_quo;
          end
        end else begin
          hi_d = fix_prod[AW-1:XLEN];
          lo_d = fix_prod[XLEN-1:0];
        end
        div_zero_d = dz_q;
        done_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      opnd_q     <= '0;
      sh_q       <= '0;
      acc_q      <= '0;
      a_raw_q    <= '0;
      neg_q      <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      opnd_q     <= opnd_d;
      sh_q       <= sh_d;
      acc_q      <= acc_d;
      a_raw_q    <= a_raw_d;
      neg_q      <= neg_d;
      neg_rem_q  <= neg_rem_d;
      dz_q       <= dz_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: a transaction-level reference model is compared every cycle,
// plus literal checks on known products and quotients.
module tb_mdu_hilo;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        mthi_we, mtlo_we;
  logic [31:0] mt_data;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  mdu_hilo dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .mthi_we(mthi_we), .mtlo_we(mtlo_we), .mt_data(mt_data),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Architectural result of one operation, from plain integer arithmetic
  function automatic void ref_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] rh, output logic [31:0] rl, output logic rz);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    rz = 1'b0;
    case (o)
      2'd0: begin p = 64'(sx * sy); rh = p[63:32]; rl = p[31:0]; end
      2'd1: begin p = {32'd0, x} * {32'd0, y}; rh = p[63:32]; rl = p[31:0]; end
      default: begin
        if (y == 32'd0) begin
          rz = 1'b1; rh = x; rl = 32'hFFFF_FFFF;
        end else if (o == 2'd2) begin
          q = sx / sy; r = sx % sy;
          p = 64'(q); rl = p[31:0];
          p = 64'(r); rh = p[31:0];
        end else begin
          rl = x / y; rh = x % y;
        end
      end
    endcase
  endfunction

  // Reference model: an accepted op completes 33 edges later; MT writes only while idle
  int          m_left = 0;
  logic        m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [31:0] r_hi, r_lo;
  logic        r_dz;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0; m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0; m_hi = '0; m_lo = '0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_hi = r_hi; m_lo = r_lo; m_dz = r_dz; m_done = 1'b1; m_busy = 1'b0;
        end
      end else if (start) begin
        ref_op(op, a, b, r_hi, r_lo, r_dz);
        m_left = 33;
        m_busy = 1'b1;
      end else begin
        if (mthi_we) m_hi = mt_data;
        if (mtlo_we) m_lo = mt_data;
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      chk("cyc busy", busy, m_busy);
      chk("cyc done", done, m_done);
      chk("cyc div_zero", div_zero, m_dz);
      chk("cyc hi", hi, m_hi);
      chk("cyc lo", lo, m_lo);
    end
  end

  // Present one start for one cycle; then scramble operands
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
  endtask

  // Count cycles until done; optional hazards (start/MT writes) early in the run
  task automatic wait_done(input bit hz, output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
      a = $urandom; b = $urandom;
      if (hz && k < 8) begin
        start = 1'b1; mtlo_we = 1'b1; mthi_we = 1'($urandom); mt_data = $urandom;
      end else begin
        start = 1'b0; mtlo_we = 1'b0; mthi_we = 1'b0;
      end
    end while (!done && k < 100);
    start = 1'b0; mtlo_we = 1'b0; mthi_we = 1'b0;
    if (k >= 100) chk("done timeout", 64'(k), 64'd33);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] eh, input logic [31:0] el, input logic ez,
                        input bit hz, input string nm);
    int k;
    issue(o, x, y);
    wait_done(hz, k);
    chk({nm, " latency"}, 64'(k), 64'd33);
    chk({nm, " hi"}, hi, eh);
    chk({nm, " lo"}, lo, el);
    chk({nm, " div_zero"}, div_zero, ez);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 8)
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom % 16);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int k;
    rst_n = 1'b0; start = 1'b0; op = 2'd0; a = '0; b = '0;
    mthi_we = 1'b0; mtlo_we = 1'b0; mt_data = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset div_zero", div_zero, 1'b0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // MTHI+MTLO together while idle
    mthi_we = 1'b1; mtlo_we = 1'b1; mt_data = 32'hDEAD_BEEF;
    @(negedge clk);
    mthi_we = 1'b0; mtlo_we = 1'b0;
    chk("mt both hi", hi, 32'hDEAD_BEEF);
    chk("mt both lo", lo, 32'hDEAD_BEEF);

    // Reset in the middle of CALC discards the op and clears HI/LO at once
    issue(2'd1, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset busy", busy, 1'b0);
    chk("midreset hi", hi, 32'd0);
    chk("midreset lo", lo, 32'd0);
    chk("midreset done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0, "multu max");
    run_op(2'd0, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0, "mult -7x3");
    run_op(2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0, 1'b0, 1'b0, "mult minsq");
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0, "div -7/2");
    run_op(2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0, "divu 100/7");
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 1'b0, "div ovf");
    run_op(2'd3, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 1'b0, "divu by0");
    run_op(2'd0, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 1'b1, "mult 2x3 hazard");

    // Back-to-back: start in the done cycle
    issue(2'd0, 32'hFFFF_FFF9, 32'd3);
    wait_done(1'b0, k);
    chk("b2b spacing", 64'(k + 1), 64'd34);
    chk("b2b hi", hi, 32'hFFFF_FFFF);
    chk("b2b lo", lo, 32'hFFFF_FFEB);

    // Randomized traffic checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      start   = (($urandom % 8) == 0);
      op      = 2'($urandom);
      a       = pick();
      b       = pick();
      mthi_we = (($urandom % 6) == 0);
      mtlo_we = (($urandom % 6) == 0);
      mt_data = $urandom;
      @(negedge clk);
    end
    start = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0;
    repeat (40) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_hilo.md
# mdu_hilo

Iterative multiply/divide unit with architectural HI/LO registers for the multi-cycle MIPS core. It sits directly downstream of the register file: its operands `a`/`b` are the registered read outputs (rs, rt) of the register file, and its results are read back by the core's MFHI/MFLO write-back path. It implements MULT, MULTU, DIV and DIVU as a 32-iteration shift/add or shift/subtract engine, plus MTHI/MTLO writes.

## Interface
- `XLEN`, 32: operand width; HI/LO are each XLEN bits, product 2*XLEN.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: launch operation; sampled only in IDLE.
- `op` in 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with `start`.
- `a` in 32: rs operand / dividend; latched on accepted `start`.
- `b` in 32: rt operand / divisor; latched on accepted `start`.
- `mthi_we` in 1: write `mt_data` to HI.
- `mtlo_we` in 1: write `mt_data` to LO.
- `mt_data` in 32: MTHI/MTLO data.
- `busy` out 1: high while an operation is in flight.
- `done` out 1: one-cycle pulse when HI/LO take a new result.
- `div_zero` out 1: valid with `done`; set when a DIV/DIVU had `b`==0.
- `hi` out 32: HI register.
- `lo` out 32: LO register.

## Operation
- States: IDLE, CALC, FIX.
- IDLE: `start`=1 at an edge → latch `op`; latch |a|,|b| (two's-complement magnitude for signed ops, raw for unsigned); record the result sign; clear 64-bit accumulator; iteration counter ← 0; → CALC.
- CALC: one iteration per cycle, counter 0..31; → FIX after the iteration with counter==31.
  - Multiply: shift-add over the 32 multiplier bits into the 64-bit accumulator.
  - Divide: restoring division; 33-bit partial remainder, 32-bit quotient built MSB first.
- FIX: apply sign correction; write HI/LO; pulse `done`; → IDLE.
  - MULT: negate the 64-bit product if sign(a)≠sign(b). HI = product[63:32], LO = product[31:0].
  - MULTU: no sign correction.
  - DIV: quotient negated if signs differ; remainder takes the sign of `a`. LO = quotient, HI = remainder.
  - DIVU: LO = quotient, HI = remainder.
- Divide by zero (`b`==0, DIV or DIVU): full latency still taken. HI = `a` (original, unmodified), LO = 32'hFFFF_FFFF, `div_zero`=1.
- Signed overflow, DIV 0x8000_0000 / 0xFFFF_FFFF: LO = 0x8000_0000, HI = 0. This falls out of the magnitude algorithm; no special case.
- `start` while `busy`: ignored; no effect on the running operation.
- MTHI/MTLO:
  - Accepted only in IDLE with `start`=0; HI/LO update at the next edge.
  - Ignored in CALC and FIX, and in the same cycle as an accepted `start`.
  - `mthi_we` and `mtlo_we` both high: both registers are written with `mt_data`.
- Operand inputs may change after acceptance without effect; HI/LO keep their old values until FIX.

## Timing
- Reset (async assert): state IDLE, counter 0, `busy`=0, `done`=0, `div_zero`=0, `hi`=0, `lo`=0. An in-flight operation is discarded.
- `start` accepted at edge N:
  - `busy`=1 from after edge N through the FIX cycle.
  - CALC iterations occupy edges N+1..N+32.
  - FIX cycle follows edge N+32; HI/LO are written at edge N+33.
  - `done`=1 and `busy`=0 for the cycle after edge N+33.
- Latency: 33 cycles from `start` to valid HI/LO.
- Back-to-back: `start` may be asserted in the same cycle `done` is high; it is accepted at the next edge.
- `div_zero`: updated only at FIX; holds its value until the next FIX or reset.

## Test plan
- Reset: hold `rst_n`=0 mid-CALC → `hi`=`lo`=0, `busy`=0 immediately. Release, then MULTU 0xFFFF_FFFF × 0xFFFF_FFFF → `hi`=0xFFFF_FFFE, `lo`=0x0000_0001, `done` exactly 33 cycles after `start`.
- MULT −7 × 3 → `hi`=0xFFFF_FFFF, `lo`=0xFFFF_FFEB. MULT 0x8000_0000 × 0x8000_0000 → `hi`=0x4000_0000, `lo`=0.
- DIV −7 / 2 → `lo`=0xFFFF_FFFD, `hi`=0xFFFF_FFFF. DIVU 100 / 7 → `lo`=14, `hi`=2. DIV 0x8000_0000 / −1 → `lo`=0x8000_0000, `hi`=0.
- DIVU 0x1234 / 0 → `hi`=0x1234, `lo`=0xFFFF_FFFF, `div_zero`=1. A following MULT 2 × 3 clears `div_zero` and gives `lo`=6.
- Hazards:
  - `start` and `mtlo_we` high during CALC → ignored; result unchanged.
  - `a`/`b` toggled during CALC → result unchanged.
  - `mthi_we`+`mtlo_we` in IDLE with 0xDEAD_BEEF → both registers read 0xDEAD_BEEF the next cycle.
- Back-to-back: `start` asserted in the `done` cycle → second `done` exactly 34 cycles after the first.
